stream_block_pooler: RTL and testbench
======================================

// Module: stream_block_pooler
// PURPOSE
//  Pixel-clock-domain successor to the VGA-side image compressor: pools a cropped window of the
//  D5M gray pixel stream (post RAW2GRAY) into an OUT_COLS x OUT_ROWS image for the CNN image_mem.
//  Generalised crop origin, block size, output size and pixel widths; adds average/max/min pooling,
//  optional inversion, a start/busy/done handshake and frame-overrun restart. Sits beside RAW2GRAY.
// PARAMETERS
//  IN_W      12   input gray pixel width
//  OUT_PW    8    output pixel width (<= IN_W)
//  ORIGIN_X  208  first sensor column of crop window
//  ORIGIN_Y  128  first sensor row of crop window
//  BLK_LG2   3    log2 of pooling block edge (BLOCK = 1<<BLK_LG2)
//  OUT_COLS  28   output columns
//  OUT_ROWS  28   output rows
//  ADDR_W    10   write address width; must satisfy 2**ADDR_W >= OUT_COLS*OUT_ROWS
// PORTS
//  D5M_PIXCLK  in   1       clock, all logic on posedge
//  rst_n       in   1       asynchronous, active-low reset
//  start       in   1       one-cycle request for one pooled frame
//  mode        in   2       00 avg, 01 max, 10 min, 11 = avg; sampled at start accept
//  invert      in   1       1: wr_data = ~pooled value; sampled at start accept
//  pix_in      in   IN_W    gray pixel
//  pix_dval    in   1       pix_in/x_cnt/y_cnt valid this cycle
//  x_cnt       in   16      sensor column of pix_in
//  y_cnt       in   16      sensor row of pix_in
//  frame_start in   1       one-cycle pulse at start of each sensor frame
//  busy        out  1       high in ARM and CAPTURE
//  done        out  1       one-cycle pulse after last output write
//  overrun     out  1       one-cycle pulse when a frame ends before window complete
//  wr_en       out  1       image_mem write strobe
//  wr_addr     out  ADDR_W  row*OUT_COLS+col
//  wr_data     out  OUT_PW  pooled pixel
// BEHAVIOUR
//  - Reset: state IDLE; busy, done, overrun, wr_en = 0; wr_addr, wr_data = 0; accumulators cleared.
//    Reset mid-frame discards all partial results; no write issued.
//  - FSM: IDLE -start-> ARM (latch mode/invert); ARM -frame_start-> CAPTURE;
//    CAPTURE -last output write-> DONE; DONE -> IDLE (done=1 that cycle).
//    start outside IDLE ignored. frame_start in CAPTURE before completion: overrun=1, stay in
//    CAPTURE, clear accumulators, restart from output (0,0) on the new frame.
//  - In-window: pix_dval & x_cnt in [ORIGIN_X, ORIGIN_X+OUT_COLS*BLOCK) & y_cnt likewise.
//    xo=x_cnt-ORIGIN_X, yo=y_cnt-ORIGIN_Y; col=xo>>BLK_LG2, row=yo>>BLK_LG2; out-of-window ignored.
//  - Per-column accumulator acc[OUT_COLS], width IN_W+2*BLK_LG2 (avg sum never overflows).
//    Pixel with xo,yo both =0 mod BLOCK loads acc[col]; other in-block pixels combine (add/max/min).
//  - Block complete on pixel with xo,yo both =BLOCK-1 mod BLOCK: result =
//    avg: (acc+pix)>>(2*BLK_LG2); max/min: combine(acc,pix); then take [IN_W-1 -: OUT_PW], invert opt.
//  - Latency: wr_en/wr_addr/wr_data registered, valid exactly 1 cycle after completing pixel;
//    wr_en high one cycle; wr_addr/wr_data hold last values otherwise.
//  - Last write is addr OUT_COLS*OUT_ROWS-1; DONE entered the cycle after that write.
//  - Stream gaps (pix_dval=0) stall nothing; pixels arrive in raster order, one per cycle max.
// TESTING  (bench params: ORIGIN_X=2, ORIGIN_Y=1, BLK_LG2=1, OUT_COLS=4, OUT_ROWS=4, IN_W=12, OUT_PW=8)
//  - Reset asserted mid-CAPTURE -> all outputs 0, state IDLE, no wr_en until next start+frame.
//  - start, frame_start, 16x16 raster pix=12'hFF0 -> 16 writes addr 0..15, data 8'hFF, done 1 cycle
//    after addr 15 write, busy low same cycle as done.
//  - mode=avg, block (0,0) pixels 12'h100,12'h200,12'h300,12'h400 -> addr 0 data 8'h28 1 cycle later.
//  - mode=max / min same block -> 8'h40 / 8'h10; invert=1 with max -> 8'hBF.
//  - Second frame_start after 5 writes -> overrun pulse, next write at addr 0, full 16 writes, done.
//  - start pulsed while busy -> ignored; pixels at x_cnt=1 or 10, y_cnt=0 or 9 -> no effect on output.

Source files
------------

// File: rtl/stream_block_pooler.sv
// Pools a cropped window of the gray pixel stream into OUT_COLS x OUT_ROWS (avg/max/min, optional invert).
// Write strobe is registered one cycle after each block's last pixel; the stream is never stalled.
module stream_block_pooler #(
  parameter int IN_W     = 12,
  parameter int OUT_PW   = 8,
  parameter int ORIGIN_X = 208,
  parameter int ORIGIN_Y = 128,
  parameter int BLK_LG2  = 3,
  parameter int OUT_COLS = 28,
  parameter int OUT_ROWS = 28,
  parameter int ADDR_W   = 10
) (
  input  logic              D5M_PIXCLK,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              invert,
  input  logic [IN_W-1:0]   pix_in,
  input  logic              pix_dval,
  input  logic [15:0]       x_cnt,
  input  logic [15:0]       y_cnt,
  input  logic              frame_start,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [OUT_PW-1:0] wr_data
);

  localparam int BLOCK = 1 << BLK_LG2;
  localparam int AW    = IN_W + 2*BLK_LG2;
  localparam int CW    = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
  localparam int RW    = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  localparam logic [15:0]       X_OFF  = 16'(ORIGIN_X);
  localparam logic [15:0]       Y_OFF  = 16'(ORIGIN_Y);
  localparam logic [16:0]       X_END  = 17'(ORIGIN_X + OUT_COLS*BLOCK);
  localparam logic [16:0]       Y_END  = 17'(ORIGIN_Y + OUT_ROWS*BLOCK);
  localparam logic [15:0]       BMASK  = 16'(BLOCK - 1);
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(OUT_COLS);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(OUT_COLS*OUT_ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic              inv_q, inv_d;
  logic              overrun_q, overrun_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [OUT_PW-1:0] wr_data_q, wr_data_d;
  logic [AW-1:0]     acc_q [OUT_COLS];
  logic [AW-1:0]     acc_d [OUT_COLS];

  logic              clear, last_done, in_win, cap_pix, blk_first, blk_last;
  logic [15:0]       xo, yo;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [AW-1:0]     acc_cur, pix_ext, comb_v, pooled, pooled_sh;
  logic [OUT_PW-1:0] res;

  assign last_done = wr_en_q && (wr_addr_q == LAST_A);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    inv_d     = inv_q;
    overrun_d = 1'b0;
    clear     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ARM;
          mode_d  = mode;
          inv_d   = invert;
          clear   = 1'b1;
        end
      end
      S_ARM: begin
        busy = 1'b1;
        if (frame_start) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        busy = 1'b1;
        // A pending final write means the window already completed; that frame_start is not an overrun.
        if (last_done) begin
          state_d = S_DONE;
        end else if (frame_start) begin
          overrun_d = 1'b1;
          clear     = 1'b1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    xo        = x_cnt - X_OFF;
    yo        = y_cnt - Y_OFF;
    col       = xo[BLK_LG2 +: CW];
    row       = yo[BLK_LG2 +: RW];
    in_win    = pix_dval && (x_cnt >= X_OFF) && ({1'b0, x_cnt} < X_END)
                         && (y_cnt >= Y_OFF) && ({1'b0, y_cnt} < Y_END);
    cap_pix   = (state_q == S_CAPTURE) && in_win && !clear;
    blk_first = ((xo & BMASK) == 16'd0) && ((yo & BMASK) == 16'd0);
    blk_last  = ((xo & BMASK) == BMASK) && ((yo & BMASK) == BMASK);
    pix_ext   = AW'(pix_in);
    acc_cur   = acc_q[col];
    case (mode_q)
      2'b01:   comb_v = (acc_cur > pix_ext) ? acc_cur : pix_ext;
      2'b10:   comb_v = (acc_cur < pix_ext) ? acc_cur : pix_ext;
      default: comb_v = acc_cur + pix_ext;
    endcase
    pooled    = ((mode_q == 2'b01) || (mode_q == 2'b10)) ? comb_v : (comb_v >> (2*BLK_LG2));
    // pooled never exceeds IN_W bits, so dropping the low bits leaves the top OUT_PW of the pixel.
    pooled_sh = pooled >> (IN_W - OUT_PW);
    res       = OUT_PW'(pooled_sh);

    acc_d = acc_q;
    if (clear) begin
      for (int i = 0; i < OUT_COLS; i++) acc_d[i] = '0;
    end else if (cap_pix) begin
      acc_d[col] = blk_first ? pix_ext : comb_v;
    end

    wr_en_d   = cap_pix && blk_last;
    wr_addr_d = wr_en_d ? (ADDR_W'(row) * COLS_A + ADDR_W'(col)) : wr_addr_q;
    wr_data_d = wr_en_d ? (inv_q ? ~res : res) : wr_data_q;
  end

  always_ff @(posedge D5M_PIXCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      inv_q     <= 1'b0;
      overrun_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < OUT_COLS; i++) acc_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      inv_q     <= inv_d;
      overrun_q <= overrun_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      acc_q     <= acc_d;
    end
  end

  assign overrun = overrun_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_stream_block_pooler.sv
// Bench for stream_block_pooler: 16x16 sensor rasters into a 4x4 pooled image of 2x2 blocks.
module tb_stream_block_pooler;

  localparam int OX = 2, OY = 1, BL = 1, NC = 4, NR = 4, IW = 12, OW = 8, AD = 4;
  localparam int BLK = 1 << BL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, invert = 1'b0, pix_dval = 1'b0, frame_start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [IW-1:0] pix_in = '0;
  logic [15:0]   x_cnt = '0, y_cnt = '0;
  logic          busy, done, overrun, wr_en;
  logic [AD-1:0] wr_addr;
  logic [OW-1:0] wr_data;

  int checks = 0;
  int failures = 0;

  logic [IW-1:0] frm [16][16];
  logic [OW-1:0] exp_img [NC*NR];
  logic [OW-1:0] got_img [NC*NR];

  stream_block_pooler #(
    .IN_W(IW), .OUT_PW(OW), .ORIGIN_X(OX), .ORIGIN_Y(OY), .BLK_LG2(BL),
    .OUT_COLS(NC), .OUT_ROWS(NR), .ADDR_W(AD)
  ) dut (
    .D5M_PIXCLK(clk), .rst_n(rst_n), .start(start), .mode(mode), .invert(invert),
    .pix_in(pix_in), .pix_dval(pix_dval), .x_cnt(x_cnt), .y_cnt(y_cnt),
    .frame_start(frame_start), .busy(busy), .done(done), .overrun(overrun),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_frame(input bit rnd);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        frm[y][x] = rnd ? 12'($urandom) : 12'hFF0;
  endtask

  // Reference image: pool each BLKxBLK window, keep the top 8 of 12 bits, optionally invert.
  task automatic build_model(input logic [1:0] md, input logic inv);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) begin
        int s, mx, mn, p;
        logic [OW-1:0] o;
        s = 0; mx = 0; mn = 4095;
        for (int dy = 0; dy < BLK; dy++)
          for (int dx = 0; dx < BLK; dx++) begin
            int v;
            v = int'(frm[OY + r*BLK + dy][OX + c*BLK + dx]);
            s += v;
            if (v > mx) mx = v;
            if (v < mn) mn = v;
          end
        p = (md == 2'b01) ? mx : (md == 2'b10) ? mn : s / (BLK*BLK);
        o = 8'(p >> (IW - OW));
        exp_img[r*NC + c] = inv ? ~o : o;
      end
  endtask

  task automatic do_start(input logic [1:0] md, input logic inv);
    mode = md; invert = inv; start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
  endtask

  // Streams one raster frame; stops early once max_writes writes have been seen (-1: never).
  task automatic run_frame(input logic active, input int max_writes, input logic poke, input logic exp_ovr);
    int nw, st;
    logic [1:0] sv_mode;
    logic sv_inv;
    nw = 0; st = 0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("fs_busy", busy, active);
    chk("fs_overrun", overrun, exp_ovr);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) begin
        bit we;
        int addr;
        pix_dval = 1'b1; x_cnt = 16'(x); y_cnt = 16'(y); pix_in = frm[y][x];
        sv_mode = mode; sv_inv = invert;
        if (poke && y == 3 && x == 0) begin
          start = 1'b1; mode = ~mode; invert = ~invert;
        end
        step();
        start = 1'b0; mode = sv_mode; invert = sv_inv;
        we = active && st == 0 && x >= OX && x < OX + NC*BLK && y >= OY && y < OY + NR*BLK
             && ((x - OX) % BLK == BLK - 1) && ((y - OY) % BLK == BLK - 1);
        addr = ((y - OY) / BLK) * NC + (x - OX) / BLK;
        chk("wr_en", wr_en, we);
        if (we) begin
          chk("wr_addr", wr_addr, addr);
          chk("wr_data", wr_data, exp_img[addr]);
          got_img[addr] = wr_data;
          nw++;
        end
        chk("busy", busy, active && st == 0);
        chk("done", done, st == 1);
        chk("overrun", overrun, 0);
        if (st == 1) st = 2;
        if (we && addr == NC*NR - 1) st = 1;
        if (nw == max_writes) begin
          pix_dval = 1'b0;
          return;
        end
      end
    pix_dval = 1'b0;
    if (active && max_writes < 0) chk("frame_completed", st, 2);
  endtask

  logic [1:0] t_md  [4] = '{2'b00, 2'b01, 2'b10, 2'b01};
  logic       t_inv [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] t_k   [4] = '{8'h28, 8'h40, 8'h10, 8'hBF};

  initial begin
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    rst_n = 1'b1;
    step();

    // constant frame, average
    fill_frame(1'b0);
    build_model(2'b00, 1'b0);
    do_start(2'b00, 1'b0);
    run_frame(1'b1, -1, 1'b0, 1'b0);
    chk("const_last", got_img[NC*NR-1], 8'hFF);
    step();

    // directed block (0,0) under each mode, random elsewhere; one run pokes start mid-capture
    for (int i = 0; i < 4; i++) begin
      fill_frame(1'b1);
      frm[1][2] = 12'h100; frm[1][3] = 12'h200; frm[2][2] = 12'h300; frm[2][3] = 12'h400;
      build_model(t_md[i], t_inv[i]);
      do_start(t_md[i], t_inv[i]);
      run_frame(1'b1, -1, i == 1, 1'b0);
      chk("blk00", got_img[0], t_k[i]);
      step();
    end

    // mode 11 behaves as average
    fill_frame(1'b1);
    build_model(2'b00, 1'b0);
    do_start(2'b11, 1'b0);
    run_frame(1'b1, -1, 1'b1, 1'b0);

    // overrun after 5 writes, then a full frame with the latched mode
    fill_frame(1'b1);
    build_model(2'b10, 1'b1);
    do_start(2'b10, 1'b1);
    run_frame(1'b1, 5, 1'b0, 1'b0);
    step();
    fill_frame(1'b1);
    build_model(2'b10, 1'b1);
    run_frame(1'b1, -1, 1'b0, 1'b1);

    // reset mid-capture
    fill_frame(1'b1);
    build_model(2'b01, 1'b0);
    do_start(2'b01, 1'b0);
    run_frame(1'b1, 6, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    step();
    rst_n = 1'b1;
    step();
    run_frame(1'b0, -1, 1'b0, 1'b0);

    // recovery after reset
    fill_frame(1'b1);
    build_model(2'b00, 1'b1);
    do_start(2'b00, 1'b1);
    run_frame(1'b1, -1, 1'b0, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
